drink_dispenser_ctrl: RTL
=========================

Name: drink_dispenser_ctrl

Overview:
- Parametrised beverage-vending controller.
- Accumulates coin credit and accepts a one-hot product selection.
- Runs that product's ingredient recipe as timed valve steps, then returns change and presents the product.
- Sits between the coin/button debouncers and the valve drivers/7-segment credit display.
- Generalises the fixed 4-drink/5-ingredient machine:
  - N products and M ingredients.
  - Per-product recipe masks.
  - Multi-coin credit accumulation with saturation.
  - Cancel/refund.
  - Insufficient-credit flag.

Parameters:
N_PROD, 4, number of selectable products
N_ING, 5, number of ingredient valves (index 0 = water … N_ING-1 = sugar)
CREDIT_W, 8, credit/price/change width in coin units of 100
STEP_CYCLES, 50_000_000, clk cycles each enabled ingredient valve stays open (>=1)
COIN_HI_VAL, 5, value of high coin in units (low coin = 1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
coin_lo  in  1  one-cycle pulse, low coin inserted
coin_hi  in  1  one-cycle pulse, high coin inserted
sel  in  N_PROD  one-cycle request pulses, one bit per product
cancel  in  1  one-cycle pulse, refund request
done_ack  in  1  customer removed product
credit  out  CREDIT_W  current credit
valve  out  N_ING  one-hot open-valve vector
busy  out  1  high outside IDLE
coin_reject  out  1  one-cycle pulse, coin arrived while not in IDLE
err_insuff  out  1  one-cycle pulse, selection with credit < price
change_valid  out  1  one-cycle pulse, change_amt meaningful
change_amt  out  CREDIT_W  amount returned
product_idx  out  $clog2(N_PROD)  latched product index
product_out  out  1  product ready for collection
state_o  out  3  encoded current state (debug display)

Behaviour:
- Reset (rst==0 at posedge clk) forces:
  - state IDLE;
  - credit, valve, change_amt, product_idx = 0;
  - all pulses and flags = 0.
- Reset mid-dispense discards credit without change.
- States and state_o encoding: IDLE=0, DISPENSE=1, CHANGE=2, DONE=3. Other codes are unreachable and return to IDLE.
- IDLE, coins:
  - credit += 1 on coin_lo, += COIN_HI_VAL on coin_hi; both in the same cycle add both.
  - Sum saturates at 2^CREDIT_W-1.
- IDLE, selection:
  - Any sel bit set: lowest set index p wins.
  - Compare against credit as registered before this cycle's coin add. The coin add still applies.
  - If credit >= PRICE[p]: latch product_idx=p, go to DISPENSE next cycle.
  - Otherwise pulse err_insuff and stay IDLE.
- IDLE, cancel (without a winning sel):
  - If credit>0: change_amt=credit, go to CHANGE.
  - If credit==0: ignored.
- IDLE, priority: sel beats cancel in the same cycle.
- DISPENSE:
  - Walks ingredient index 0..N_ING-1 in order.
  - Skips indices whose RECIPE[p] bit is 0, with no cycles spent on skipped indices.
  - Each enabled index holds valve=one-hot(index) for exactly STEP_CYCLES cycles, with no gap cycle between consecutive enabled steps.
  - After the last enabled step, set change_amt = credit − PRICE[p] and go to CHANGE.
  - RECIPE[p]==0 goes to CHANGE directly, after 1 cycle in DISPENSE with valve=0.
  - cancel and sel are ignored. Coins pulse coin_reject and do not alter credit.
- CHANGE (1 cycle):
  - change_valid=1, credit cleared to 0 at the end of the cycle.
  - Go to DONE if entered from DISPENSE, else go to IDLE.
  - Coins pulse coin_reject.
- DONE:
  - product_out=1 until done_ack. done_ack → IDLE next cycle.
  - Coins pulse coin_reject.
- busy = (state != IDLE). valve = 0 outside DISPENSE.
- All outputs registered; latency from input pulse to output response is one clk.

Decomposition:
- Package dispenser_pkg holds:
  - state_t enum;
  - PRICE[N_PROD] table (default 3,4,5,7);
  - RECIPE[N_PROD] N_ING-bit masks (defaults 5'b00011, 5'b00101, 5'b01001, 5'b10111);
  - COIN_LO_VAL=1.
- One sub-module, step_timer:
  - Parametrised down-counter of STEP_CYCLES with load/enable.
  - Raises a one-cycle expire strobe.
  - Sync active-low rst.

Test Plan (STEP_CYCLES=4, defaults otherwise):
- coin_hi, then sel[1] → credit=5, DISPENSE. valve=00001 for 4 cycles, then valve=00100 for 4 cycles. change_valid with change_amt=1, product_out=1. done_ack → IDLE, credit=0.
- 2×coin_lo, then sel[0] (price 3) → err_insuff pulse, credit stays 2. cancel → change_valid with change_amt=2, back to IDLE, product_out never asserts.
- coin_hi+coin_lo in the same cycle → credit=6. Then sel[3] (price 7) → err_insuff. coin_lo+sel[3] in the same cycle → err_insuff, credit=7. Next sel[3] → DISPENSE. Valves 0,1,2,4, 16 cycles total. change_amt=0.
- Saturation: CREDIT_W=4, four coin_hi → credit=15, not 4.
- coin_lo pulses during DISPENSE and DONE → coin_reject each time, credit unchanged. sel[0]|sel[2] in the same cycle → product_idx=0.
- rst=0 for one cycle at the 3rd cycle of the second valve step → next cycle: IDLE, valve=0, credit=0, no change_valid.

Source files
------------

// File: rtl/drink_dispenser_ctrl_pkg.sv
// Shared types and product tables for the drink dispenser.
// Products beyond the table have price 0 and an empty recipe.
package dispenser_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPENSE = 3'd1,
        CHANGE   = 3'd2,
        DONE     = 3'd3
    } state_t;

    localparam int N_TBL       = 4;
    localparam int N_ING_TBL   = 5;
    localparam int COIN_LO_VAL = 1;

    localparam int PRICE [N_TBL] = '{3, 4, 5, 7};

    localparam logic [N_ING_TBL-1:0] RECIPE [N_TBL] = '{
        5'b00011, 5'b00101, 5'b01001, 5'b10111
    };

    function automatic int price_of(input int p);
        if (p < 0 || p >= N_TBL) return 0;
        return PRICE[p[1:0]];
    endfunction

    function automatic logic [31:0] recipe_of(input int p);
        if (p < 0 || p >= N_TBL) return '0;
        return 32'(RECIPE[p[1:0]]);
    endfunction

endpackage

// File: rtl/drink_dispenser_ctrl_step_timer.sv
// Auto-reloading valve step timer.
// expire is high on the last cycle of each STEP_CYCLES window.
module step_timer #(
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] TOP = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // count down, reload on load or on reaching zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= TOP;
        end else if (en) begin
            cnt_q <= (cnt_q == '0) ? TOP : cnt_q - CW'(1);
        end
    end

    assign expire = en && !load && (cnt_q == '0);

endmodule

// File: rtl/drink_dispenser_ctrl.sv
// Vending controller: credit, selection, timed recipe, change.
// Every output is a register updated one clock after its cause.
module drink_dispenser_ctrl
    import dispenser_pkg::*;
#(
    parameter int N_PROD      = 4,
    parameter int N_ING       = 5,
    parameter int CREDIT_W    = 8,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int COIN_HI_VAL = 5,
    localparam int PIDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_lo,
    input  logic                coin_hi,
    input  logic [N_PROD-1:0]   sel,
    input  logic                cancel,
    input  logic                done_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ING-1:0]    valve,
    output logic                busy,
    output logic                coin_reject,
    output logic                err_insuff,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [PIDX_W-1:0]   product_idx,
    output logic                product_out,
    output logic [2:0]          state_o
);

    localparam int ING_W = (N_ING > 1) ? $clog2(N_ING) : 1;
    localparam logic [CREDIT_W-1:0] CRED_MAX = '1;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, credit_sat;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [N_ING-1:0]    valve_q, valve_d;
    logic [PIDX_W-1:0]   pidx_q, pidx_d, sel_idx;
    logic [ING_W-1:0]    ing_q, ing_d, first_idx, nxt_idx;
    logic                first_ok, nxt_ok;
    logic                from_disp_q, from_disp_d;
    logic                rej_q, rej_d, insuff_q, insuff_d;
    logic                cv_q, cv_d, pout_q, pout_d, busy_q, busy_d;
    logic                tmr_load, tmr_en, tmr_exp;
    logic [CREDIT_W-1:0] sel_price, cur_price;
    logic [N_ING-1:0]    sel_rcp, cur_rcp;
    logic [31:0]         coin_sum;
    logic                coin_any;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .en    (tmr_en),
        .expire(tmr_exp)
    );

    // lowest requested product and saturating coin sum
    always_comb begin
        sel_idx = '0;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (sel[i]) sel_idx = PIDX_W'(i);
        end
        sel_price = CREDIT_W'(price_of(int'(sel_idx)));
        cur_price = CREDIT_W'(price_of(int'(pidx_q)));
        sel_rcp   = N_ING'(recipe_of(int'(sel_idx)));
        cur_rcp   = N_ING'(recipe_of(int'(pidx_q)));
        coin_any  = coin_lo | coin_hi;
        coin_sum  = 32'(credit_q)
                  + (coin_lo ? 32'(COIN_LO_VAL) : 32'd0)
                  + (coin_hi ? 32'(COIN_HI_VAL) : 32'd0);
        credit_sat = (coin_sum > 32'(CRED_MAX)) ? CRED_MAX
                                                 : CREDIT_W'(coin_sum);
    end

    // first enabled ingredient of the new product, next one of the current
    always_comb begin
        first_idx = '0;
        first_ok  = 1'b0;
        nxt_idx   = '0;
        nxt_ok    = 1'b0;
        for (int i = N_ING - 1; i >= 0; i--) begin
            if (sel_rcp[i]) begin
                first_idx = ING_W'(i);
                first_ok  = 1'b1;
            end
            if (cur_rcp[i] && i > int'(ing_q)) begin
                nxt_idx = ING_W'(i);
                nxt_ok  = 1'b1;
            end
        end
    end

    // next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        change_d    = change_q;
        valve_d     = valve_q;
        pidx_d      = pidx_q;
        ing_d       = ing_q;
        from_disp_d = from_disp_q;
        rej_d       = 1'b0;
        insuff_d    = 1'b0;
        cv_d        = 1'b0;
        pout_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                valve_d  = '0;
                credit_d = credit_sat;
                if (|sel) begin
                    if (credit_q >= sel_price) begin
                        pidx_d      = sel_idx;
                        from_disp_d = 1'b1;
                        tmr_load    = 1'b1;
                        ing_d       = first_idx;
                        valve_d     = first_ok ? (N_ING'(1) << first_idx) : '0;
                        state_d     = DISPENSE;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end else if (cancel && credit_q != '0) begin
                    change_d    = credit_q;
                    from_disp_d = 1'b0;
                    cv_d        = 1'b1;
                    state_d     = CHANGE;
                end
            end
            DISPENSE: begin
                rej_d  = coin_any;
                tmr_en = 1'b1;
                if (cur_rcp == '0 || (tmr_exp && !nxt_ok)) begin
                    valve_d  = '0;
                    change_d = credit_q - cur_price;
                    cv_d     = 1'b1;
                    state_d  = CHANGE;
                end else if (tmr_exp) begin
                    ing_d   = nxt_idx;
                    valve_d = N_ING'(1) << nxt_idx;
                end
            end
            CHANGE: begin
                rej_d    = coin_any;
                credit_d = '0;
                pout_d   = from_disp_q;
                state_d  = from_disp_q ? DONE : IDLE;
            end
            DONE: begin
                rej_d  = coin_any;
                pout_d = !done_ack;
                if (done_ack) state_d = IDLE;
            end
            default: begin
                valve_d = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            change_q    <= '0;
            valve_q     <= '0;
            pidx_q      <= '0;
            ing_q       <= '0;
            from_disp_q <= 1'b0;
            rej_q       <= 1'b0;
            insuff_q    <= 1'b0;
            cv_q        <= 1'b0;
            pout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            change_q    <= change_d;
            valve_q     <= valve_d;
            pidx_q      <= pidx_d;
            ing_q       <= ing_d;
            from_disp_q <= from_disp_d;
            rej_q       <= rej_d;
            insuff_q    <= insuff_d;
            cv_q        <= cv_d;
            pout_q      <= pout_d;
            busy_q      <= busy_d;
        end
    end

    assign credit       = credit_q;
    assign valve        = valve_q;
    assign busy         = busy_q;
    assign coin_reject  = rej_q;
    assign err_insuff   = insuff_q;
    assign change_valid = cv_q;
    assign change_amt   = change_q;
    assign product_idx  = pidx_q;
    assign product_out  = pout_q;
    assign state_o      = state_q;

endmodule
